// File: rtl/gridwalk_pkg.sv
// ============================================================================
// Module   : gridwalk_pkg
// Purpose  : Command field layout and operation codes shared by gridwalk_param
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gridwalk_pkg;

  localparam int SUB_BIT  = 0;
  localparam int AXIS_BIT = 1;
  localparam int MAG_LSB  = 2;

  localparam logic AXIS_X = 1'b1;
  localparam logic AXIS_Y = 1'b0;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_MOVE = 2'd1,
    OP_UNDO = 2'd2
  } op_e;

endpackage

`default_nettype wire

// File: rtl/gridwalk_hist.sv
// ============================================================================
// Module   : gridwalk_hist
// Purpose  : Position history LIFO; a push when full overwrites the oldest entry
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gridwalk_hist #(
  parameter  int HIST_DEPTH = 4,
  parameter  int ENTRY_W    = 8,
  localparam int CNT_W      = $clog2(HIST_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [ENTRY_W-1:0] i_din,
  output logic [ENTRY_W-1:0] o_top,
  output logic [CNT_W-1:0]   o_count
);

  localparam int PTR_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
  localparam logic [PTR_W-1:0] c_last_idx = PTR_W'(HIST_DEPTH - 1);
  localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(HIST_DEPTH);

  logic [ENTRY_W-1:0] r_mem [HIST_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic             w_do_push;
  logic             w_do_pop;
  logic [PTR_W-1:0] w_wr_inc;
  logic [PTR_W-1:0] w_rd_dec;

  // Push wins over pop so a caller never has to arbitrate.
  assign w_do_push = i_push;
  assign w_do_pop  = i_pop & ~i_push & (r_count != '0);

  // Pointers walk a ring of HIST_DEPTH slots, so depth need not be a power of two.
  assign w_wr_inc = (r_wr_ptr == c_last_idx) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_dec = (r_rd_ptr == '0) ? c_last_idx : r_rd_ptr - 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_do_push) begin
      r_rd_ptr <= r_wr_ptr;
      r_wr_ptr <= w_wr_inc;
      if (r_count != c_full_cnt) begin
        r_count <= r_count + 1'b1;
      end
    end else if (w_do_pop) begin
      r_wr_ptr <= r_rd_ptr;
      r_rd_ptr <= w_rd_dec;
      r_count  <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  assign o_top   = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/gridwalk_param.sv
// ============================================================================
// Module   : gridwalk_param
// Purpose  : Edge-commanded X/Y position stepper with saturate/wrap and undo
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gridwalk_param
  import gridwalk_pkg::*;
#(
  parameter  int COORD_W    = 4,
  parameter  int STEP_W     = 2,
  parameter  int WRAP       = 0,
  parameter  int HIST_DEPTH = 4,
  localparam int HCNT_W     = $clog2(HIST_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rot_event,
  input  logic [STEP_W+1:0]    y,
  input  logic                 undo,
  output logic [2*COORD_W-1:0] led,
  output logic                 clamp,
  output logic [HCNT_W-1:0]    hist_cnt
);

  logic               r_prev_rot;
  logic               r_prev_undo;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic               r_clamp;

  logic                 w_rot_edge;
  logic                 w_undo_edge;
  op_e                  w_op;
  logic                 w_sub;
  logic                 w_axis_x;
  logic [COORD_W:0]     w_mag_ext;
  logic [COORD_W-1:0]   w_cur;
  logic [COORD_W:0]     w_sum;
  logic                 w_ovf;
  logic [COORD_W-1:0]   w_next;
  logic [2*COORD_W-1:0] w_top;
  logic [HCNT_W-1:0]    w_hist_cnt;

  assign w_rot_edge  = rot_event & ~r_prev_rot;
  assign w_undo_edge = undo & ~r_prev_undo;

  // A move on the same edge as an undo takes priority; the undo is dropped.
  always_comb begin
    w_op = OP_NONE;
    if (w_rot_edge) begin
      w_op = OP_MOVE;
    end else if (w_undo_edge) begin
      w_op = OP_UNDO;
    end
  end

  assign w_sub     = y[SUB_BIT];
  assign w_axis_x  = (y[AXIS_BIT] == AXIS_X);
  assign w_mag_ext = {{(COORD_W + 1 - STEP_W){1'b0}}, y[MAG_LSB +: STEP_W]};
  assign w_cur     = w_axis_x ? r_x : r_y;
  assign w_sum     = w_sub ? ({1'b0, w_cur} - w_mag_ext) : ({1'b0, w_cur} + w_mag_ext);
  // The extra top bit is the carry on add and the borrow on subtract.
  assign w_ovf     = w_sum[COORD_W];

  generate
    if (WRAP != 0) begin : g_wrap
      assign w_next = w_sum[COORD_W-1:0];
    end else begin : g_sat
      assign w_next = w_ovf ? (w_sub ? '0 : '1) : w_sum[COORD_W-1:0];
    end
  endgenerate

  gridwalk_hist #(
    .HIST_DEPTH (HIST_DEPTH),
    .ENTRY_W    (2 * COORD_W)
  ) u_hist (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_op == OP_MOVE),
    .i_pop   (w_op == OP_UNDO),
    .i_din   ({r_y, r_x}),
    .o_top   (w_top),
    .o_count (w_hist_cnt)
  );

  // Edge history resets high so a level already asserted at release is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_rot  <= 1'b1;
      r_prev_undo <= 1'b1;
      r_x         <= '0;
      r_y         <= '0;
      r_clamp     <= 1'b0;
    end else begin
      r_prev_rot  <= rot_event;
      r_prev_undo <= undo;
      r_clamp     <= 1'b0;
      case (w_op)
        OP_MOVE: begin
          if (w_axis_x) begin
            r_x <= w_next;
          end else begin
            r_y <= w_next;
          end
          r_clamp <= w_ovf;
        end
        OP_UNDO: begin
          if (w_hist_cnt != '0) begin
            {r_y, r_x} <= w_top;
          end
        end
        default: ;
      endcase
    end
  end

  assign led      = {r_y, r_x};
  assign clamp    = r_clamp;
  assign hist_cnt = w_hist_cnt;

endmodule

`default_nettype wire

// File: tb/tb_gridwalk_param.sv
// ============================================================================
// Module   : tb_gridwalk_param
// Purpose  : Scoreboard bench driving a saturating and a wrapping instance
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gridwalk_param;

  localparam int CW = 4;
  localparam int SW = 2;
  localparam int HD = 4;
  localparam int HW = $clog2(HD + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rot_event = 1'b0;
  logic          undo = 1'b0;
  logic [SW+1:0] y = '0;
  logic          chk = 1'b0;

  logic [2*CW-1:0] led_s, led_w;
  logic            clamp_s, clamp_w;
  logic [HW-1:0]   cnt_s, cnt_w;

  typedef struct packed {
    logic [2*CW-1:0] ls;
    logic [2*CW-1:0] lw;
    logic            cl;
    logic [HW-1:0]   cnt;
  } exp_t;

  exp_t  q[$];
  string qn[$];
  int    tests = 0;
  int    fails = 0;

  always #5 clk = ~clk;

  gridwalk_param #(.COORD_W(CW), .STEP_W(SW), .WRAP(0), .HIST_DEPTH(HD)) dut_sat (
    .clk(clk), .rst(rst), .rot_event(rot_event), .y(y), .undo(undo),
    .led(led_s), .clamp(clamp_s), .hist_cnt(cnt_s)
  );

  gridwalk_param #(.COORD_W(CW), .STEP_W(SW), .WRAP(1), .HIST_DEPTH(HD)) dut_wrap (
    .clk(clk), .rst(rst), .rot_event(rot_event), .y(y), .undo(undo),
    .led(led_w), .clamp(clamp_w), .hist_cnt(cnt_w)
  );

  function automatic logic [2*CW-1:0] pos(input int x, input int yy);
    return {yy[CW-1:0], x[CW-1:0]};
  endfunction

  task automatic push_exp(input int xs, input int ys, input int xw, input int yw,
                          input logic cl, input int cnt, input string nm);
    exp_t e;
    e.ls  = pos(xs, ys);
    e.lw  = pos(xw, yw);
    e.cl  = cl;
    e.cnt = HW'(cnt);
    q.push_back(e);
    qn.push_back(nm);
  endtask

  // Inputs change on the falling edge; the expectation covers the next rising edge.
  task automatic cyc(input logic r, input logic u, input logic [SW+1:0] yv,
                     input int xs, input int ys, input int xw, input int yw,
                     input logic cl, input int cnt, input string nm);
    @(negedge clk);
    rot_event = r;
    undo      = u;
    y         = yv;
    push_exp(xs, ys, xw, yw, cl, cnt, nm);
  endtask

  task automatic async_rst(input logic r, input string nm);
    @(negedge clk);
    rot_event = r;
    undo      = 1'b0;
    #2;
    rst = 1'b1;
    push_exp(0, 0, 0, 0, 1'b0, 0, nm);
    chk = 1'b1;
    #1;
    chk = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk or posedge chk);
      #1;
      if (q.size() > 0) begin
        e  = q.pop_front();
        nm = qn.pop_front();
        tests++;
        if (led_s !== e.ls || led_w !== e.lw || clamp_s !== e.cl || clamp_w !== e.cl ||
            cnt_s !== e.cnt || cnt_w !== e.cnt) begin
          fails++;
          $display("FAIL %s: got led_sat=%h led_wrap=%h clamp=%b/%b cnt=%0d/%0d, want led_sat=%h led_wrap=%h clamp=%b cnt=%0d",
                   nm, led_s, led_w, clamp_s, clamp_w, cnt_s, cnt_w, e.ls, e.lw, e.cl, e.cnt);
        end
      end
    end
  end

  initial begin : stimulus
    #2;
    push_exp(0, 0, 0, 0, 1'b0, 0, "reset_state");
    chk = 1'b1;
    #1;
    chk = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    cyc(0, 0, 4'b1110, 0, 0, 0, 0, 0, 0, "idle_after_reset");
    cyc(1, 0, 4'b1110, 3, 0, 3, 0, 0, 1, "x_plus3_a");
    cyc(0, 0, 4'b1110, 3, 0, 3, 0, 0, 1, "hold_a");
    cyc(1, 0, 4'b1110, 6, 0, 6, 0, 0, 2, "x_plus3_b");
    cyc(0, 0, 4'b1110, 6, 0, 6, 0, 0, 2, "hold_b");
    cyc(1, 0, 4'b1110, 9, 0, 9, 0, 0, 3, "x_plus3_c");
    cyc(0, 0, 4'b1110, 9, 0, 9, 0, 0, 3, "hold_c");
    cyc(1, 0, 4'b1110, 12, 0, 12, 0, 0, 4, "x_to_12");
    cyc(0, 0, 4'b1110, 12, 0, 12, 0, 0, 4, "hold_12");
    cyc(1, 0, 4'b1010, 14, 0, 14, 0, 0, 4, "x_to_14_hist_full");
    cyc(0, 0, 4'b1010, 14, 0, 14, 0, 0, 4, "hold_14");
    cyc(1, 0, 4'b1010, 15, 0, 0, 0, 1, 4, "x_carry_sat_wrap");
    cyc(0, 0, 4'b1010, 15, 0, 0, 0, 0, 4, "clamp_one_cycle_x");
    cyc(1, 0, 4'b0100, 15, 1, 0, 1, 0, 4, "y_plus1");
    cyc(0, 0, 4'b0100, 15, 1, 0, 1, 0, 4, "hold_y1");
    cyc(1, 0, 4'b1101, 15, 0, 0, 14, 1, 4, "y_borrow_sat_wrap");
    cyc(0, 0, 4'b1101, 15, 0, 0, 14, 0, 4, "clamp_one_cycle_y");

    // Ring kept only the newest four pre-move positions.
    cyc(0, 1, 4'b1101, 15, 1, 0, 1, 0, 3, "ring_undo_1");
    cyc(0, 0, 4'b1101, 15, 1, 0, 1, 0, 3, "ring_hold_1");
    cyc(0, 1, 4'b1101, 15, 0, 0, 0, 0, 2, "ring_undo_2");
    cyc(0, 0, 4'b1101, 15, 0, 0, 0, 0, 2, "ring_hold_2");
    cyc(0, 1, 4'b1101, 14, 0, 14, 0, 0, 1, "ring_undo_3");
    cyc(0, 0, 4'b1101, 14, 0, 14, 0, 0, 1, "ring_hold_3");
    cyc(0, 1, 4'b1101, 12, 0, 12, 0, 0, 0, "ring_undo_4");
    cyc(0, 0, 4'b1101, 12, 0, 12, 0, 0, 0, "ring_hold_4");
    cyc(0, 1, 4'b1101, 12, 0, 12, 0, 0, 0, "undo_when_empty");
    cyc(0, 0, 4'b1101, 12, 0, 12, 0, 0, 0, "hold_empty");

    async_rst(0, "async_reset_a");
    cyc(0, 0, 4'b0110, 0, 0, 0, 0, 0, 0, "idle_after_reset_a");
    for (int i = 1; i <= 5; i++) begin
      cyc(1, 0, 4'b0110, i, 0, i, 0, 0, (i > HD) ? HD : i, "five_moves");
      cyc(0, 0, 4'b0110, i, 0, i, 0, 0, (i > HD) ? HD : i, "five_moves_hold");
    end
    for (int i = 4; i >= 1; i--) begin
      cyc(0, 1, 4'b0110, i, 0, i, 0, 0, i - 1, "undo_seq");
      cyc(0, 0, 4'b0110, i, 0, i, 0, 0, i - 1, "undo_seq_hold");
    end
    cyc(0, 1, 4'b0110, 1, 0, 1, 0, 0, 0, "fifth_undo_ignored");
    cyc(0, 0, 4'b0110, 1, 0, 1, 0, 0, 0, "fifth_undo_hold");

    cyc(1, 0, 4'b0110, 2, 0, 2, 0, 0, 1, "x_to_2");
    cyc(0, 0, 4'b0110, 2, 0, 2, 0, 0, 1, "hold_2");
    cyc(1, 1, 4'b0110, 3, 0, 3, 0, 0, 2, "move_beats_undo");
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 4'b0110, 3, 0, 3, 0, 0, 2, "rot_level_held");
    end
    cyc(0, 0, 4'b0110, 3, 0, 3, 0, 0, 2, "rot_released");

    cyc(0, 1, 4'b0110, 2, 0, 2, 0, 0, 1, "undo_to_2");
    cyc(0, 0, 4'b0110, 2, 0, 2, 0, 0, 1, "hold_undo_2");
    cyc(0, 1, 4'b0110, 1, 0, 1, 0, 0, 0, "undo_to_1");
    cyc(0, 0, 4'b0110, 1, 0, 1, 0, 0, 0, "hold_undo_1");
    cyc(1, 0, 4'b1110, 4, 0, 4, 0, 0, 1, "x_to_4");
    cyc(0, 0, 4'b1110, 4, 0, 4, 0, 0, 1, "hold_4");
    cyc(1, 0, 4'b1110, 7, 0, 7, 0, 0, 2, "x_to_7");
    cyc(0, 0, 4'b1110, 7, 0, 7, 0, 0, 2, "hold_7");

    async_rst(1, "async_reset_mid_op");
    cyc(1, 0, 4'b1110, 0, 0, 0, 0, 0, 0, "rot_high_thru_release_a");
    cyc(1, 0, 4'b1110, 0, 0, 0, 0, 0, 0, "rot_high_thru_release_b");
    cyc(0, 0, 4'b1110, 0, 0, 0, 0, 0, 0, "rot_low_after_release");
    cyc(1, 0, 4'b1110, 3, 0, 3, 0, 0, 1, "rearmed_move");

    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      @(posedge clk);
    end
    #3;
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
